// File: rtl/ir_nec_transmitter.sv
`timescale 1ns/1ps
// Purpose: NEC IR transmitter; sends {~cmd,cmd,~addr,addr} LSB first on a modulated carrier, then optional repeat codes.
// Latency: leader mark starts the cycle after tx_valid && tx_ready; frames/repeats start every T_FRAME cycles.
// Backpressure: tx_ready is high only in IDLE; requests arriving while busy are dropped, never queued.
module ir_nec_transmitter #(
   parameter int CARRIER_DIV  = 1316,
   parameter int CARRIER_HIGH = 438,
   parameter int T_UNIT       = 28125,
   parameter int T_FRAME      = 5400000
) (
   input  logic       clk_50,
   input  logic       rst_n,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic [7:0] tx_addr,
   input  logic [7:0] tx_cmd,
   input  logic       repeat_hold,
   output logic       irda_txd,
   output logic       busy,
   output logic       frame_done
);

   // Counters cover the longest mark and the frame period, never narrower than 23 bits.
   localparam int DUR_MAX   = (16 * T_UNIT > T_FRAME) ? 16 * T_UNIT : T_FRAME;
   localparam int CNT_W_RAW = $clog2(DUR_MAX + 1);
   localparam int CNT_W     = (CNT_W_RAW < 23) ? 23 : CNT_W_RAW;
   localparam int CAR_W     = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

   // Terminal counts: a state lasting N cycles ends when its counter equals N-1.
   localparam logic [CNT_W-1:0] LEAD_MARK_LAST  = CNT_W'(16 * T_UNIT - 1);
   localparam logic [CNT_W-1:0] LEAD_SPACE_LAST = CNT_W'(8 * T_UNIT - 1);
   localparam logic [CNT_W-1:0] UNIT_LAST       = CNT_W'(T_UNIT - 1);
   localparam logic [CNT_W-1:0] ONE_SPACE_LAST  = CNT_W'(3 * T_UNIT - 1);
   localparam logic [CNT_W-1:0] REP_SPACE_LAST  = CNT_W'(4 * T_UNIT - 1);
   localparam logic [CNT_W-1:0] FRAME_LAST      = CNT_W'(T_FRAME - 1);
   localparam logic [CAR_W-1:0] CAR_LAST        = CAR_W'(CARRIER_DIV - 1);
   localparam logic [CAR_W-1:0] CAR_HIGH        = CAR_W'(CARRIER_HIGH);

   typedef enum logic [3:0] {
      IDLE,
      LEAD_MARK,
      LEAD_SPACE,
      BIT_MARK,
      BIT_SPACE,
      STOP_MARK,
      GAP,
      REP_MARK,
      REP_SPACE,
      REP_STOP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] dur_q, dur_d;
   logic [CNT_W-1:0] frame_q, frame_d;
   logic [CAR_W-1:0] car_q, car_d;
   logic [5:0]       bit_q, bit_d;
   logic [31:0]      word_q, word_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] dur_lim;
   logic             dur_end;
   logic             is_mark;

   // Last count of the current state; a data bit's space length depends on the bit being sent.
   always_comb begin
      dur_lim = '0;
      case (state_q)
         LEAD_MARK:  dur_lim = LEAD_MARK_LAST;
         LEAD_SPACE: dur_lim = LEAD_SPACE_LAST;
         BIT_MARK:   dur_lim = UNIT_LAST;
         BIT_SPACE:  dur_lim = word_q[0] ? ONE_SPACE_LAST : UNIT_LAST;
         STOP_MARK:  dur_lim = UNIT_LAST;
         REP_MARK:   dur_lim = LEAD_MARK_LAST;
         REP_SPACE:  dur_lim = REP_SPACE_LAST;
         REP_STOP:   dur_lim = UNIT_LAST;
         default:    dur_lim = '0;
      endcase
   end

   assign dur_end = (dur_q == dur_lim);

   // Mark states are the ones that drive the carrier onto the LED.
   always_comb begin
      is_mark = 1'b0;
      case (state_q)
         LEAD_MARK, BIT_MARK, STOP_MARK, REP_MARK, REP_STOP: is_mark = 1'b1;
         default: is_mark = 1'b0;
      endcase
   end

   // Next-state logic: sequence the frame, shift out the word, time the frame period.
   always_comb begin
      state_d = state_q;
      dur_d   = dur_q + 1'b1;
      frame_d = frame_q + 1'b1;
      car_d   = (car_q == CAR_LAST) ? '0 : car_q + 1'b1;
      bit_d   = bit_q;
      word_d  = word_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            dur_d   = '0;
            frame_d = '0;
            car_d   = '0;
            if (tx_valid) begin
               word_d  = {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
               bit_d   = '0;
               state_d = LEAD_MARK;
            end
         end
         LEAD_MARK:  if (dur_end) state_d = LEAD_SPACE;
         LEAD_SPACE: if (dur_end) state_d = BIT_MARK;
         BIT_MARK:   if (dur_end) state_d = BIT_SPACE;
         BIT_SPACE: begin
            if (dur_end) begin
               word_d = {1'b0, word_q[31:1]};
               if (bit_q == 6'd31) begin
                  state_d = STOP_MARK;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  state_d = BIT_MARK;
               end
            end
         end
         STOP_MARK: begin
            if (dur_end) begin
               done_d  = 1'b1;
               state_d = GAP;
            end
         end
         GAP: begin
            if (frame_q == FRAME_LAST) begin
               frame_d = '0;
               state_d = repeat_hold ? REP_MARK : IDLE;
            end
         end
         REP_MARK:  if (dur_end) state_d = REP_SPACE;
         REP_SPACE: if (dur_end) state_d = REP_STOP;
         REP_STOP: begin
            if (dur_end) begin
               done_d  = 1'b1;
               state_d = GAP;
            end
         end
         default: state_d = IDLE;
      endcase

      // Every state starts timing from zero, and every mark starts on a high carrier phase.
      if (state_d != state_q) begin
         dur_d = '0;
         car_d = '0;
      end
   end

   // State and datapath registers; reset aborts any frame in progress.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dur_q   <= '0;
         frame_q <= '0;
         car_q   <= '0;
         bit_q   <= '0;
         word_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dur_q   <= dur_d;
         frame_q <= frame_d;
         car_q   <= car_d;
         bit_q   <= bit_d;
         word_q  <= word_d;
         done_q  <= done_d;
      end
   end

   assign tx_ready   = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign frame_done = done_q;
   assign irda_txd   = is_mark && (car_q < CAR_HIGH);

endmodule

// File: doc/ir_nec_transmitter.md
IR_NEC_TRANSMITTER -- requirements
Module: ir_nec_transmitter

Interface
REQ-001 The block SHALL provide parameter CARRIER_DIV, default 1316, meaning the 38 kHz carrier period in clk_50 cycles.
REQ-002 The block SHALL provide parameter CARRIER_HIGH, default 438, meaning carrier high cycles per period (about 1/3 duty).
REQ-003 The block SHALL provide parameter T_UNIT, default 28125, meaning the 562.5 us NEC base unit in clk_50 cycles.
REQ-004 The block SHALL provide parameter T_FRAME, default 5400000, meaning the 108 ms frame repetition period in clk_50 cycles.
REQ-005 The block SHALL have port clk_50  input  1  single system clock, 50 MHz; all logic on its rising edge.
REQ-006 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 The block SHALL have port tx_valid  input  1  request to send one frame.
REQ-008 The block SHALL have port tx_ready  output  1  high when a request can be accepted.
REQ-009 The block SHALL have port tx_addr  input  8  NEC address byte.
REQ-010 The block SHALL have port tx_cmd  input  8  NEC command byte (same code space IR_button decodes).
REQ-011 The block SHALL have port repeat_hold  input  1  high means send NEC repeat codes after the frame.
REQ-012 The block SHALL have port irda_txd  output  1  modulated IR LED drive, active high.
REQ-013 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 The block SHALL have port frame_done  output  1  one-cycle pulse at the end of each frame or repeat stop mark.

Function
REQ-015 The FSM SHALL have states IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP, REP_MARK, REP_SPACE, REP_STOP.
REQ-016 tx_ready SHALL equal (state==IDLE); a transfer occurs on a cycle with tx_valid && tx_ready.
REQ-017 On transfer, the block SHALL latch the 32-bit word {~tx_cmd, tx_cmd, ~tx_addr, tx_addr} and enter LEAD_MARK on the next cycle.
REQ-018 Input changes on tx_addr/tx_cmd after transfer SHALL NOT affect the frame in progress.
REQ-019 Durations SHALL be: LEAD_MARK 16*T_UNIT; LEAD_SPACE 8*T_UNIT; BIT_MARK T_UNIT; BIT_SPACE T_UNIT for a 0 and 3*T_UNIT for a 1; STOP_MARK T_UNIT; REP_MARK 16*T_UNIT; REP_SPACE 4*T_UNIT; REP_STOP T_UNIT.
REQ-020 Bits SHALL be sent LSB first from bit 0 to bit 31; a 6-bit-safe index advances after each BIT_SPACE, and BIT_SPACE of bit 31 goes to STOP_MARK.
REQ-021 In mark states irda_txd SHALL be high while the carrier counter is < CARRIER_HIGH, else low; the counter wraps at CARRIER_DIV-1.
REQ-022 The carrier counter SHALL restart at 0 on the first cycle of every mark state, so each mark begins with a high carrier phase.
REQ-023 In IDLE, space and GAP states irda_txd SHALL be low.
REQ-024 A frame-period counter SHALL start at 0 on the first cycle of LEAD_MARK or REP_MARK and count every cycle.
REQ-025 STOP_MARK and REP_STOP completion SHALL pulse frame_done for exactly one cycle and enter GAP.
REQ-026 GAP SHALL exit when the frame-period counter reaches T_FRAME-1: to REP_MARK if repeat_hold is high on that cycle, else to IDLE.
REQ-027 tx_valid asserted during any non-IDLE state SHALL be ignored (not queued).
REQ-028 repeat_hold SHALL be sampled only at GAP exit; toggling elsewhere has no effect.
REQ-029 Duration counters SHALL be wide enough for 16*T_UNIT and T_FRAME without overflow at default parameters (at least 23 bits).

Reset
REQ-030 While rst_n is low, state SHALL be IDLE, irda_txd=0, busy=0, frame_done=0, tx_ready=1, all counters and the shift word 0.
REQ-031 Reset assertion mid-frame SHALL immediately force irda_txd low and abort the frame; no partial frame resumes after release.
REQ-032 After rst_n deasserts, the first transfer SHALL be accepted on the first rising edge with tx_valid high.

Verification
REQ-033 Bench: tx_addr=0x00, tx_cmd=0x45, pulse tx_valid -> leader 450000 modulated cycles, 225000 low, 32 bits decoding to word 0xBA45FF00, stop mark, one frame_done pulse, IDLE at 5400000 cycles after leader start.
REQ-034 Bench: repeat_hold=1 through two periods -> two repeat codes (450000 mark, 112500 space, 28125 mark) starting 5400000 cycles apart, frame_done pulses 3 total; drop repeat_hold -> IDLE after the current GAP.
REQ-035 Bench: during a mark measure irda_txd -> high 438 cycles, low 878 cycles, period 1316, first cycle of each mark high.
REQ-036 Bench: tx_valid held high for the whole frame with changing tx_cmd -> exactly one frame with the originally latched command; next frame starts only after return to IDLE.
REQ-037 Bench: assert rst_n low during bit 10 of a frame -> irda_txd=0 and busy=0 within the same cycle; after release, no output until a new transfer.
REQ-038 Bench: scaled parameters (CARRIER_DIV=6, CARRIER_HIGH=2, T_UNIT=12, T_FRAME=2000) -> same state sequence and cycle-exact durations.
